sprite_rom_arbiter: RTL and testbench
=====================================

SPRITE_ROM_ARBITER -- requirements
Module: sprite_rom_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters (0 score, 1 dino, 2 obstacle, 3 cloud).
REQ-002 Parameter ADDR_W, default 18: sprite ROM address width.
REQ-003 Parameter DATA_W, default 4: ROM word width (palette index).
REQ-004 Parameter ROM_LAT, default 2: cycles from rom_addr presented to matching rom_q valid.
REQ-005 Parameter ROM_DEPTH, default 171995: valid addresses 0..ROM_DEPTH-1.
REQ-006 Clk50  input  1  sole clock, all state on rising edge.
REQ-007 Reset_n  input  1  asynchronous, active-low reset.
REQ-008 enable  input  1  high permits new grants; low blocks grants, in-flight reads still drain.
REQ-009 req  input  N_REQ  per-requester read request, held until granted.
REQ-010 addr  input  N_REQ*ADDR_W  packed request addresses, slice i for requester i.
REQ-011 gnt  output  N_REQ  one-hot combinational grant; request accepted in any cycle with req[i]&gnt[i].
REQ-012 rom_addr  output  ADDR_W  registered address to sprite ROM.
REQ-013 rom_rd_en  output  1  registered, high in cycles rom_addr carries an accepted read.
REQ-014 rom_q  input  DATA_W  ROM read data.
REQ-015 rd_valid  output  N_REQ  registered one-hot, return-data strobe for requester i.
REQ-016 rd_data  output  DATA_W  registered return data, meaningful only with rd_valid.
REQ-017 starve_err  output  1  sticky, set when any requester waits N_REQ or more cycles with enable high.
REQ-018 oob_err  output  1  sticky, set when an accepted address is >= ROM_DEPTH.

Function
REQ-019 Arbitration shall be round-robin: winner is first i with req[i]=1 scanning from rr_ptr upward, wrapping N_REQ-1 to 0.
REQ-020 At most one gnt bit shall be high per cycle; gnt shall be all zero when enable=0 or req=0.
REQ-021 After a grant to i, rr_ptr shall become (i+1) mod N_REQ on the next edge; rr_ptr unchanged when no grant.
REQ-022 Grant in cycle T: rom_addr/rom_rd_en valid in T+1, rom_q sampled in T+1+ROM_LAT, rd_valid/rd_data valid in T+2+ROM_LAT (4 cycles at defaults).
REQ-023 Back-to-back grants every cycle shall be sustained; throughput 1 read/cycle, returns in grant order.
REQ-024 A tag shift register of depth ROM_LAT+1 shall carry requester index and valid bit alongside each read.
REQ-025 rom_addr shall hold its last value when rom_rd_en=0.
REQ-026 Out-of-range accepted address: grant proceeds, rom_addr driven 0, rd_data returned as 0 with rd_valid, oob_err set.
REQ-027 Per-requester wait counter: increments while req[i]=1 and gnt[i]=0 and enable=1, clears on grant or req drop; value N_REQ sets starve_err.
REQ-028 enable deassert mid-stream: no new grants from that cycle; all previously accepted reads still return.
REQ-029 Requester dropping req without grant shall not be granted and leaves rr_ptr unaffected.

Reset
REQ-030 Reset_n low shall asynchronously clear rr_ptr=0, rom_addr=0, rom_rd_en=0, rd_valid=0, rd_data=0, tags, wait counters, starve_err=0, oob_err=0.
REQ-031 Reads in flight at reset shall be discarded; no rd_valid until a new grant after release.
REQ-032 Sticky errors clear only by reset.

Structure
REQ-033 Shared package shall hold requester index constants (REQ_SCORE=0, REQ_DINO=1, REQ_OBST=2, REQ_CLOUD=3), ROM_DEPTH and the sprite base-address constants (e.g. NUM0_BASE=168215).
REQ-034 Round-robin selection shall be a sub-module rr_pick (req, rr_ptr -> one-hot gnt, winner index), purely combinational.

Verification
REQ-035 Single req[0]=1, addr0=168215, enable=1, ROM model returns addr[3:0] -> gnt[0] in T, rom_addr=168215 in T+1, rd_valid=0001 with rd_data=0x7 in T+4.
REQ-036 req=1111 held, distinct addresses -> grants 0,1,2,3,0 on consecutive cycles, rd_valid sequence 0001,0010,0100,1000 from T+4, starve_err stays 0.
REQ-037 req[3] alone granted, then req=1001 -> next grant goes to 0 (rr_ptr wrapped to 0).
REQ-038 addr1=171995 accepted -> rom_addr=0, rd_valid=0010 with rd_data=0 four cycles later, oob_err=1 and stays 1.
REQ-039 enable=0 for 5 cycles with req[2]=1 -> gnt=0, starve_err=0; three grants issued before enable drop still return.
REQ-040 Reset_n pulsed low 1 cycle after two grants -> all outputs zero immediately, no rd_valid afterwards, next grant goes to lowest requesting index.

Source files
------------

// File: rtl/sprite_rom_arbiter_pkg.sv
// Shared constants for the sprite ROM arbiter: requester indices, ROM geometry
// and sprite base addresses used by the drawing requesters.
package sprite_rom_arbiter_pkg;

  localparam int REQ_SCORE = 0;
  localparam int REQ_DINO  = 1;
  localparam int REQ_OBST  = 2;
  localparam int REQ_CLOUD = 3;

  localparam int ROM_DEPTH = 171995;

  localparam int NUM0_BASE = 168215;

  // Index width for n items, kept at least one bit so a single requester still elaborates.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sprite_rom_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or above rr_ptr wins,
// scanning upward and wrapping to 0.
module rr_pick
  import sprite_rom_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int PW    = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    rr_ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [PW-1:0]    idx,
  output logic             hit
);

  always_comb begin
    int cand;
    cand = 0;
    gnt  = '0;
    idx  = '0;
    hit  = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = (int'(rr_ptr) + k) % N_REQ;
      if (!hit && req[cand]) begin
        hit       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = PW'(cand);
      end
    end
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one fixed-latency sprite ROM between the score, dino, obstacle and cloud
// drawers; each read returns to its requester ROM_LAT+2 cycles after the grant.
module sprite_rom_arbiter #(
  parameter int N_REQ     = 4,
  parameter int ADDR_W    = 18,
  parameter int DATA_W    = 4,
  parameter int ROM_LAT   = 2,
  parameter int ROM_DEPTH = 171995
) (
  input  logic                    Clk50,
  input  logic                    Reset_n,
  input  logic                    enable,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] addr,
  output logic [N_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]       rom_addr,
  output logic                    rom_rd_en,
  input  logic [DATA_W-1:0]       rom_q,
  output logic [N_REQ-1:0]        rd_valid,
  output logic [DATA_W-1:0]       rd_data,
  output logic                    starve_err,
  output logic                    oob_err
);
  import sprite_rom_arbiter_pkg::*;

  localparam int PW = idx_w(N_REQ);
  localparam int CW = $clog2(N_REQ + 1);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(ROM_DEPTH);

  // Handshake: req[i] is valid, gnt[i] is ready; a read is accepted in any cycle
  // with req[i] & gnt[i], and req[i]/addr slice i must hold steady until then.

  logic [PW-1:0]     rr_ptr;
  logic [N_REQ-1:0]  req_en;
  logic [N_REQ-1:0]  pick_gnt;
  logic [PW-1:0]     pick_idx;
  logic              pick_hit;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_oob;

  assign req_en = req & {N_REQ{enable}};

  rr_pick #(.N_REQ(N_REQ), .PW(PW)) u_pick (
    .req    (req_en),
    .rr_ptr (rr_ptr),
    .gnt    (pick_gnt),
    .idx    (pick_idx),
    .hit    (pick_hit)
  );

  assign gnt = pick_gnt;

  always_comb begin
    sel_addr = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_gnt[i]) sel_addr = addr[i*ADDR_W +: ADDR_W];
    end
  end

  assign sel_oob = ({1'b0, sel_addr} >= DEPTH_L);

  always_ff @(posedge Clk50 or negedge Reset_n) begin
    if (!Reset_n) begin
      rr_ptr <= '0;
    end else if (pick_hit) begin
      rr_ptr <= (pick_idx == PW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
    end
  end

  // Out-of-range reads still occupy a slot so returns stay in grant order.
  always_ff @(posedge Clk50 or negedge Reset_n) begin
    if (!Reset_n) begin
      rom_addr  <= '0;
      rom_rd_en <= 1'b0;
    end else begin
      rom_rd_en <= pick_hit;
      if (pick_hit) rom_addr <= sel_oob ? '0 : sel_addr;
    end
  end

  logic [ROM_LAT:0] tag_vld;
  logic [ROM_LAT:0] tag_oob;
  logic [PW-1:0]    tag_idx [ROM_LAT+1];

  always_ff @(posedge Clk50 or negedge Reset_n) begin
    if (!Reset_n) begin
      tag_vld <= '0;
      tag_oob <= '0;
      for (int k = 0; k <= ROM_LAT; k++) tag_idx[k] <= '0;
    end else begin
      tag_vld[0] <= pick_hit;
      tag_oob[0] <= sel_oob;
      tag_idx[0] <= pick_idx;
      for (int k = 1; k <= ROM_LAT; k++) begin
        tag_vld[k] <= tag_vld[k-1];
        tag_oob[k] <= tag_oob[k-1];
        tag_idx[k] <= tag_idx[k-1];
      end
    end
  end

  logic [N_REQ-1:0] ret_oh;

  always_comb begin
    ret_oh = '0;
    for (int i = 0; i < N_REQ; i++) ret_oh[i] = (int'(tag_idx[ROM_LAT]) == i);
  end

  // The last tag stage lines up with the cycle rom_q holds that read's data.
  always_ff @(posedge Clk50 or negedge Reset_n) begin
    if (!Reset_n) begin
      rd_valid <= '0;
      rd_data  <= '0;
    end else if (tag_vld[ROM_LAT]) begin
      rd_valid <= ret_oh;
      rd_data  <= tag_oob[ROM_LAT] ? '0 : rom_q;
    end else begin
      rd_valid <= '0;
      rd_data  <= '0;
    end
  end

  logic [CW-1:0] wait_cnt [N_REQ];
  logic          starve_hit;

  always_comb begin
    starve_hit = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (wait_cnt[i] >= CW'(N_REQ)) starve_hit = 1'b1;
    end
  end

  always_ff @(posedge Clk50 or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < N_REQ; i++) wait_cnt[i] <= '0;
      starve_err <= 1'b0;
      oob_err    <= 1'b0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!req[i] || pick_gnt[i]) wait_cnt[i] <= '0;
        else if (enable && wait_cnt[i] != CW'(N_REQ)) wait_cnt[i] <= wait_cnt[i] + 1'b1;
      end
      starve_err <= starve_err | starve_hit;
      oob_err    <= oob_err | (pick_hit & sel_oob);
    end
  end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter with a fixed-latency ROM model that
// returns the low address nibble.
module tb_sprite_rom_arbiter;
  import sprite_rom_arbiter_pkg::*;

  localparam int N_REQ   = 4;
  localparam int ADDR_W  = 18;
  localparam int DATA_W  = 4;
  localparam int ROM_LAT = 2;
  localparam int SBW     = N_REQ + DATA_W;

  logic                    Clk50   = 1'b0;
  logic                    Reset_n = 1'b0;
  logic                    enable  = 1'b0;
  logic [N_REQ-1:0]        req     = '0;
  logic [N_REQ*ADDR_W-1:0] addr    = '0;
  logic [N_REQ-1:0]        gnt;
  logic [ADDR_W-1:0]       rom_addr;
  logic                    rom_rd_en;
  logic [DATA_W-1:0]       rom_q;
  logic [N_REQ-1:0]        rd_valid;
  logic [DATA_W-1:0]       rd_data;
  logic                    starve_err;
  logic                    oob_err;

  int n_checks = 0;
  int n_fail   = 0;
  logic [SBW-1:0] exp_q[$];

  sprite_rom_arbiter #(
    .N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(ROM_LAT), .ROM_DEPTH(171995)
  ) dut (
    .Clk50      (Clk50),
    .Reset_n    (Reset_n),
    .enable     (enable),
    .req        (req),
    .addr       (addr),
    .gnt        (gnt),
    .rom_addr   (rom_addr),
    .rom_rd_en  (rom_rd_en),
    .rom_q      (rom_q),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .starve_err (starve_err),
    .oob_err    (oob_err)
  );

  // ---------------- clock / ROM model ----------------
  always #10 Clk50 = ~Clk50;

  logic [DATA_W-1:0] rom_pipe [ROM_LAT];
  always @(posedge Clk50) begin
    rom_pipe[0] <= rom_addr[DATA_W-1:0];
    for (int k = 1; k < ROM_LAT; k++) rom_pipe[k] <= rom_pipe[k-1];
  end
  assign rom_q = rom_pipe[ROM_LAT-1];

  // ---------------- return scoreboard ----------------
  always @(negedge Clk50) begin
    if (Reset_n && rd_valid != '0) begin
      logic [SBW-1:0] exp;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: rd_valid=%b rd_data=%h, none expected", rd_valid, rd_data);
      end else begin
        exp = exp_q.pop_front();
        if ({rd_valid, rd_data} !== exp) begin
          n_fail++;
          $display("FAIL sb_return: got rd_valid=%b rd_data=%h, expected %b / %h",
                   rd_valid, rd_data, exp[SBW-1:DATA_W], exp[DATA_W-1:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    Reset_n = 1'b0;
    enable  = 1'b0;
    req     = '0;
    addr    = '0;
    repeat (2) @(negedge Clk50);
    Reset_n = 1'b1;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    enable  = 1'b0;
    req     = '0;
    repeat (2) @(negedge Clk50);
    n_checks++; if (rom_addr !== '0) begin n_fail++; $display("FAIL reset_rom_addr: got %h expected 0", rom_addr); end
    n_checks++; if (rom_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rom_rd_en: got %b expected 0", rom_rd_en); end
    n_checks++; if (rd_valid !== '0) begin n_fail++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
    n_checks++; if (rd_data !== '0) begin n_fail++; $display("FAIL reset_rd_data: got %h expected 0", rd_data); end
    n_checks++; if (starve_err !== 1'b0) begin n_fail++; $display("FAIL reset_starve: got %b expected 0", starve_err); end
    n_checks++; if (oob_err !== 1'b0) begin n_fail++; $display("FAIL reset_oob: got %b expected 0", oob_err); end
    n_checks++; if (gnt !== '0) begin n_fail++; $display("FAIL reset_gnt: got %b expected 0", gnt); end
    Reset_n = 1'b1;
  endtask

  task automatic test_single_read();
    do_reset();
    @(negedge Clk50);
    enable = 1'b1;
    addr[REQ_SCORE*ADDR_W +: ADDR_W] = ADDR_W'(NUM0_BASE);
    req = 4'b0001;
    exp_q.push_back({4'b0001, 4'h7});
    #1;
    n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL single_gnt: got %b expected 0001", gnt); end
    @(negedge Clk50);
    n_checks++; if (rom_addr !== 18'd168215) begin n_fail++; $display("FAIL single_rom_addr: got %0d expected 168215", rom_addr); end
    n_checks++; if (rom_rd_en !== 1'b1) begin n_fail++; $display("FAIL single_rd_en: got %b expected 1", rom_rd_en); end
    req = '0;
    @(negedge Clk50);
    n_checks++; if (rom_rd_en !== 1'b0) begin n_fail++; $display("FAIL single_rd_en_off: got %b expected 0", rom_rd_en); end
    n_checks++; if (rom_addr !== 18'd168215) begin n_fail++; $display("FAIL single_addr_hold: got %0d expected 168215", rom_addr); end
    @(negedge Clk50);
    n_checks++; if (rd_valid !== 4'b0000) begin n_fail++; $display("FAIL single_early: got %b expected 0000", rd_valid); end
    @(negedge Clk50);
    n_checks++; if (rd_valid !== 4'b0001) begin n_fail++; $display("FAIL single_rd_valid: got %b expected 0001", rd_valid); end
    n_checks++; if (rd_data !== 4'h7) begin n_fail++; $display("FAIL single_rd_data: got %h expected 7", rd_data); end
    @(negedge Clk50);
    n_checks++; if (rd_valid !== 4'b0000) begin n_fail++; $display("FAIL single_late: got %b expected 0000", rd_valid); end
  endtask

  task automatic test_round_robin();
    logic [3:0]        eg [10] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0};
    logic [3:0]        ev [10] = '{4'b0, 4'b0, 4'b0, 4'b0, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0};
    logic [3:0]        ed [10] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h1, 4'h0};
    logic              er [10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [ADDR_W-1:0] ea [10] = '{18'h0, 18'h11, 18'h22, 18'h33, 18'h44, 18'h11, 18'h11, 18'h11, 18'h11, 18'h11};
    do_reset();
    enable = 1'b1;
    addr = {18'h00044, 18'h00033, 18'h00022, 18'h00011};
    exp_q.push_back({4'b0001, 4'h1});
    exp_q.push_back({4'b0010, 4'h2});
    exp_q.push_back({4'b0100, 4'h3});
    exp_q.push_back({4'b1000, 4'h4});
    exp_q.push_back({4'b0001, 4'h1});
    for (int c = 0; c < 10; c++) begin
      @(negedge Clk50);
      n_checks++; if (rom_rd_en !== er[c]) begin n_fail++; $display("FAIL rr_rd_en c=%0d: got %b expected %b", c, rom_rd_en, er[c]); end
      n_checks++; if (rom_addr !== ea[c]) begin n_fail++; $display("FAIL rr_rom_addr c=%0d: got %h expected %h", c, rom_addr, ea[c]); end
      n_checks++; if (rd_valid !== ev[c]) begin n_fail++; $display("FAIL rr_rd_valid c=%0d: got %b expected %b", c, rd_valid, ev[c]); end
      if (ev[c] != 4'b0) begin
        n_checks++; if (rd_data !== ed[c]) begin n_fail++; $display("FAIL rr_rd_data c=%0d: got %h expected %h", c, rd_data, ed[c]); end
      end
      req = (c < 5) ? 4'b1111 : 4'b0000;
      #1;
      n_checks++; if (gnt !== eg[c]) begin n_fail++; $display("FAIL rr_gnt c=%0d: got %b expected %b", c, gnt, eg[c]); end
    end
    n_checks++; if (starve_err !== 1'b0) begin n_fail++; $display("FAIL rr_starve: got %b expected 0", starve_err); end
  endtask

  task automatic test_wrap();
    logic [3:0] rq [8] = '{4'b1000, 4'b1001, 4'b1000, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0};
    logic [3:0] eg [8] = '{4'b1000, 4'b0001, 4'b1000, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0};
    logic [3:0] ev [8] = '{4'b0, 4'b0, 4'b0, 4'b0, 4'b1000, 4'b0001, 4'b1000, 4'b0};
    logic [3:0] ed [8] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h5, 4'h6, 4'h5, 4'h0};
    do_reset();
    enable = 1'b1;
    addr[REQ_CLOUD*ADDR_W +: ADDR_W] = 18'h00035;
    addr[REQ_SCORE*ADDR_W +: ADDR_W] = 18'h00016;
    exp_q.push_back({4'b1000, 4'h5});
    exp_q.push_back({4'b0001, 4'h6});
    exp_q.push_back({4'b1000, 4'h5});
    for (int c = 0; c < 8; c++) begin
      @(negedge Clk50);
      n_checks++; if (rd_valid !== ev[c]) begin n_fail++; $display("FAIL wrap_rd_valid c=%0d: got %b expected %b", c, rd_valid, ev[c]); end
      if (ev[c] != 4'b0) begin
        n_checks++; if (rd_data !== ed[c]) begin n_fail++; $display("FAIL wrap_rd_data c=%0d: got %h expected %h", c, rd_data, ed[c]); end
      end
      req = rq[c];
      #1;
      n_checks++; if (gnt !== eg[c]) begin n_fail++; $display("FAIL wrap_gnt c=%0d: got %b expected %b", c, gnt, eg[c]); end
    end
  endtask

  task automatic test_oob();
    do_reset();
    @(negedge Clk50);
    enable = 1'b1;
    addr[REQ_DINO*ADDR_W +: ADDR_W] = 18'd171994;
    req = 4'b0010;
    exp_q.push_back({4'b0010, 4'hA});
    exp_q.push_back({4'b0010, 4'h0});
    #1;
    n_checks++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL oob_gnt_edge: got %b expected 0010", gnt); end
    @(negedge Clk50);
    n_checks++; if (rom_addr !== 18'd171994) begin n_fail++; $display("FAIL oob_edge_addr: got %0d expected 171994", rom_addr); end
    n_checks++; if (oob_err !== 1'b0) begin n_fail++; $display("FAIL oob_edge_err: got %b expected 0", oob_err); end
    addr[REQ_DINO*ADDR_W +: ADDR_W] = 18'd171995;
    #1;
    n_checks++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL oob_gnt: got %b expected 0010", gnt); end
    @(negedge Clk50);
    n_checks++; if (rom_addr !== '0) begin n_fail++; $display("FAIL oob_rom_addr: got %0d expected 0", rom_addr); end
    n_checks++; if (rom_rd_en !== 1'b1) begin n_fail++; $display("FAIL oob_rd_en: got %b expected 1", rom_rd_en); end
    n_checks++; if (oob_err !== 1'b1) begin n_fail++; $display("FAIL oob_err_set: got %b expected 1", oob_err); end
    req = '0;
    repeat (2) @(negedge Clk50);
    n_checks++; if (rd_valid !== 4'b0010) begin n_fail++; $display("FAIL oob_edge_valid: got %b expected 0010", rd_valid); end
    n_checks++; if (rd_data !== 4'hA) begin n_fail++; $display("FAIL oob_edge_data: got %h expected a", rd_data); end
    @(negedge Clk50);
    n_checks++; if (rd_valid !== 4'b0010) begin n_fail++; $display("FAIL oob_valid: got %b expected 0010", rd_valid); end
    n_checks++; if (rd_data !== 4'h0) begin n_fail++; $display("FAIL oob_data: got %h expected 0", rd_data); end
    repeat (3) @(negedge Clk50);
    n_checks++; if (oob_err !== 1'b1) begin n_fail++; $display("FAIL oob_sticky: got %b expected 1", oob_err); end
  endtask

  task automatic test_enable_drop();
    logic       en [14] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [3:0] rq [14] = '{4'b0111, 4'b0110, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100,
                           4'b0, 4'b0, 4'b0, 4'b0, 4'b0};
    logic [3:0] eg [14] = '{4'b0001, 4'b0010, 4'b0100, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0100,
                           4'b0, 4'b0, 4'b0, 4'b0, 4'b0};
    logic       er [14] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [3:0] ev [14] = '{4'b0, 4'b0, 4'b0, 4'b0, 4'b0001, 4'b0010, 4'b0100, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0,
                           4'b0100, 4'b0};
    logic [3:0] ed [14] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h9, 4'hA, 4'hB, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hB, 4'h0};
    do_reset();
    addr = {18'h0, 18'h0003B, 18'h0002A, 18'h00019};
    exp_q.push_back({4'b0001, 4'h9});
    exp_q.push_back({4'b0010, 4'hA});
    exp_q.push_back({4'b0100, 4'hB});
    exp_q.push_back({4'b0100, 4'hB});
    for (int c = 0; c < 14; c++) begin
      @(negedge Clk50);
      n_checks++; if (rom_rd_en !== er[c]) begin n_fail++; $display("FAIL en_rd_en c=%0d: got %b expected %b", c, rom_rd_en, er[c]); end
      n_checks++; if (rd_valid !== ev[c]) begin n_fail++; $display("FAIL en_rd_valid c=%0d: got %b expected %b", c, rd_valid, ev[c]); end
      if (ev[c] != 4'b0) begin
        n_checks++; if (rd_data !== ed[c]) begin n_fail++; $display("FAIL en_rd_data c=%0d: got %h expected %h", c, rd_data, ed[c]); end
      end
      enable = en[c];
      req    = rq[c];
      #1;
      n_checks++; if (gnt !== eg[c]) begin n_fail++; $display("FAIL en_gnt c=%0d: got %b expected %b", c, gnt, eg[c]); end
    end
    n_checks++; if (starve_err !== 1'b0) begin n_fail++; $display("FAIL en_starve: got %b expected 0", starve_err); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge Clk50);
    enable = 1'b1;
    addr = {18'h0004E, 18'h0002D, 18'h0001C, 18'h0};
    req = 4'b0110;
    #1;
    n_checks++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL rst_gnt0: got %b expected 0010", gnt); end
    @(negedge Clk50);
    req = 4'b0100;
    #1;
    n_checks++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL rst_gnt1: got %b expected 0100", gnt); end
    @(negedge Clk50);
    req = '0;
    Reset_n = 1'b0;
    #1;
    n_checks++; if (rom_addr !== '0) begin n_fail++; $display("FAIL rst_rom_addr: got %h expected 0", rom_addr); end
    n_checks++; if (rom_rd_en !== 1'b0) begin n_fail++; $display("FAIL rst_rd_en: got %b expected 0", rom_rd_en); end
    n_checks++; if (rd_valid !== '0) begin n_fail++; $display("FAIL rst_rd_valid: got %b expected 0", rd_valid); end
    n_checks++; if (rd_data !== '0) begin n_fail++; $display("FAIL rst_rd_data: got %h expected 0", rd_data); end
    @(negedge Clk50);
    Reset_n = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(negedge Clk50);
      n_checks++; if (rd_valid !== '0) begin n_fail++; $display("FAIL rst_stale c=%0d: got %b expected 0000", c, rd_valid); end
    end
    req = 4'b1010;
    exp_q.push_back({4'b0010, 4'hC});
    #1;
    n_checks++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL rst_regrant: got %b expected 0010", gnt); end
    @(negedge Clk50);
    req = '0;
    repeat (5) @(negedge Clk50);
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_wrap();
    test_oob();
    test_enable_drop();
    test_reset_mid();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: got %0d returns outstanding, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
